rr_matrix_inverter: RTL and testbench



---
 rtl/rr_matrix_inverter.sv | 160 ++++++++++++++++
 tb/tb_rr_matrix_inverter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_matrix_inverter.sv
// ---------------------------------------------------------------------------
// rr_matrix_inverter
//   Sequential GF(2) matrix inverter for the redundant-representation
//   datapath. Runs Gauss-Jordan elimination on [M | I] one column at a time:
//   a PIVOT cycle (find and swap a pivot row), then an ELIM cycle (clear the
//   column in every other row, all rows in parallel).
//
//   Ports:
//     clk         clock
//     rst         synchronous active-high reset, aborts any operation
//     start       request inversion, sampled only when idle
//     matrix_in   N x N matrix to invert, captured on the accepted start
//     busy        high while pivoting/eliminating
//     done        one-cycle completion pulse
//     singular    matrix had no inverse; held until the next accepted start
//     matrix_out  inverse (all-zero when singular), held between completions
//
//   Row i of a matrix is matrix[i]; element (i, j) is matrix[i][j].
// ---------------------------------------------------------------------------
package types;
  localparam int d = 4;
  localparam int N = 8 + d;
  typedef logic [N-1:0][N-1:0] rr_matrix_t;
endpackage

module rr_matrix_inverter #(
  parameter int d = types::d
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  types::rr_matrix_t matrix_in,
  output logic              busy,
  output logic              done,
  output logic              singular,
  output types::rr_matrix_t matrix_out
);

  localparam int N     = 8 + d;
  localparam int COL_W = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PIVOT = 2'd1,
    S_ELIM  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [N-1:0][N-1:0]     r_a;         // working copy of M
  logic [N-1:0][N-1:0]     r_b;         // accumulating inverse
  logic [COL_W-1:0]        r_col;
  logic                    r_singular;
  logic [N-1:0][N-1:0]     r_out;

  logic [N-1:0][N-1:0]     w_ident;
  logic                    w_piv_found;
  logic [COL_W-1:0]        w_piv_idx;
  logic [N-1:0][N-1:0]     w_a_swap;
  logic [N-1:0][N-1:0]     w_b_swap;
  logic [N-1:0][N-1:0]     w_a_elim;
  logic [N-1:0][N-1:0]     w_b_elim;
  logic                    w_last_col;

  assign w_last_col = (r_col == COL_W'(N - 1));

  // Identity matrix and per-row elimination, one generate lane per row.
  // Elimination reads only registered values, so row col is used in its
  // pre-update form by every other row.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    logic w_hit;
    assign w_ident[gi]  = {{(N-1){1'b0}}, 1'b1} << gi;
    assign w_hit        = (COL_W'(gi) != r_col) && r_a[gi][r_col];
    assign w_a_elim[gi] = w_hit ? (r_a[gi] ^ r_a[r_col]) : r_a[gi];
    assign w_b_elim[gi] = w_hit ? (r_b[gi] ^ r_b[r_col]) : r_b[gi];
  end

  // Lowest row index >= col with a 1 in column col. Scanning downwards lets
  // the last match (the lowest index) win.
  always_comb begin
    w_piv_found = 1'b0;
    w_piv_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if ((COL_W'(i) >= r_col) && r_a[i][r_col]) begin
        w_piv_found = 1'b1;
        w_piv_idx   = COL_W'(i);
      end
    end
  end

  // Swap rows col and pivot in both halves; harmless when they are equal.
  always_comb begin
    w_a_swap             = r_a;
    w_b_swap             = r_b;
    w_a_swap[r_col]      = r_a[w_piv_idx];
    w_a_swap[w_piv_idx]  = r_a[r_col];
    w_b_swap[r_col]      = r_b[w_piv_idx];
    w_b_swap[w_piv_idx]  = r_b[r_col];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_PIVOT;
      S_PIVOT: w_state_next = w_piv_found ? S_ELIM : S_DONE;
      S_ELIM:  w_state_next = w_last_col ? S_DONE : S_PIVOT;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_col      <= '0;
      r_singular <= 1'b0;
      r_out      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a        <= matrix_in;
            r_b        <= w_ident;
            r_col      <= '0;
            r_singular <= 1'b0;
          end
        end
        S_PIVOT: begin
          if (w_piv_found) begin
            r_a <= w_a_swap;
            r_b <= w_b_swap;
          end else begin
            r_singular <= 1'b1;
            r_out      <= '0;
          end
        end
        S_ELIM: begin
          r_a <= w_a_elim;
          r_b <= w_b_elim;
          if (w_last_col) r_out <= w_b_elim;
          else            r_col <= r_col + COL_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state == S_PIVOT) || (r_state == S_ELIM);
  assign done       = (r_state == S_DONE);
  assign singular   = r_singular;
  assign matrix_out = r_out;

endmodule

// File: tb/tb_rr_matrix_inverter.sv
// ---------------------------------------------------------------------------
// tb_rr_matrix_inverter
//   Randomized self-checking bench. The reference is algebraic: a result is
//   accepted when M * out = I and (x*M)*out = x; singularity and latency are
//   predicted from the rank of the leading columns of M, computed with an
//   XOR-basis rank routine.
//   Latency is counted in clock edges, the start edge being edge 1.
// ---------------------------------------------------------------------------
module tb_rr_matrix_inverter;

  localparam int N = types::N;
  typedef types::rr_matrix_t mat_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  mat_t matrix_in;
  logic busy;
  logic done;
  logic singular;
  mat_t matrix_out;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  rr_matrix_inverter dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .matrix_in  (matrix_in),
    .busy       (busy),
    .done       (done),
    .singular   (singular),
    .matrix_out (matrix_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] got,
                           input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference helpers ----------------
  function automatic logic [N-1:0] vmul(input logic [N-1:0] x, input mat_t m);
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++) if (x[i]) r ^= m[i];
    return r;
  endfunction

  function automatic int rank_of(input mat_t m, input logic [N-1:0] mask);
    logic [N-1:0] basis [N];
    logic [N-1:0] v;
    logic         placed;
    int           rk = 0;
    for (int b = 0; b < N; b++) basis[b] = '0;
    for (int i = 0; i < N; i++) begin
      v      = m[i] & mask;
      placed = 1'b0;
      for (int b = N - 1; b >= 0; b--) begin
        if (!placed && v[b]) begin
          if (basis[b] == '0) begin
            basis[b] = v;
            rk++;
            placed = 1'b1;
          end else begin
            v ^= basis[b];
          end
        end
      end
    end
    return rk;
  endfunction

  // First column c that lies in the span of columns 0..c-1; N if none.
  function automatic int first_dep_col(input mat_t m);
    logic [N-1:0] mask = '0;
    for (int c = 0; c < N; c++) begin
      mask[c] = 1'b1;
      if (rank_of(m, mask) <= c) return c;
    end
    return N;
  endfunction

  function automatic mat_t ident();
    mat_t r = '0;
    for (int i = 0; i < N; i++) r[i][i] = 1'b1;
    return r;
  endfunction

  function automatic mat_t rand_invertible();
    mat_t r = ident();
    logic [N-1:0] t;
    for (int k = 0; k < 60; k++) begin
      int i = $urandom_range(N - 1);
      int j = $urandom_range(N - 1);
      if (i != j) begin
        if ($urandom_range(3) == 0) begin
          t = r[i]; r[i] = r[j]; r[j] = t;
        end else begin
          r[i] ^= r[j];
        end
      end
    end
    return r;
  endfunction

  function automatic mat_t rand_mat();
    mat_t r;
    for (int i = 0; i < N; i++) r[i] = N'($urandom);
    return r;
  endfunction

  // ---------------- transaction ----------------
  // Runs one inversion. If inject > 0, a second start with m2 is pulsed when
  // the edge count reaches inject (must be ignored by the DUT).
  task automatic run_one(input mat_t m, input int inject, input mat_t m2,
                         output int lat, output int busy_n,
                         output logic sing, output mat_t out);
    logic seen = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    matrix_in = m;
    @(negedge clk);
    start     = 1'b0;
    matrix_in = rand_mat();
    lat       = 1;
    busy_n    = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_n++;
        start     = (inject > 0) && (lat == inject);
        matrix_in = start ? m2 : rand_mat();
        @(negedge clk);
        lat++;
      end
    end
    start = 1'b0;
    check_val("done_seen", seen, 1'b1);
    check_val("busy_at_done", busy, 1'b0);
    sing = singular;
    out  = matrix_out;
    @(negedge clk);
    check_val("done_pulse", done, 1'b0);
  endtask

  task automatic verify(input string tag, input mat_t m, input int lat,
                        input int busy_n, input logic sing, input mat_t out);
    int   c        = first_dep_col(m);
    logic exp_sing = (c < N);
    mat_t prod;
    logic [N-1:0] x;
    txn++;
    $display("txn %0d %s: singular=%0d latency=%0d busy=%0d dep_col=%0d",
             txn, tag, sing, lat, busy_n, c);
    check_val({tag, "_singular"}, sing, exp_sing);
    check_val({tag, "_latency"}, lat, exp_sing ? 2 * c + 2 : 2 * N + 1);
    check_val({tag, "_busy_cycles"}, busy_n, exp_sing ? 2 * c + 1 : 2 * N);
    if (exp_sing) begin
      check_val({tag, "_out_zero"}, out, '0);
    end else begin
      for (int i = 0; i < N; i++) prod[i] = vmul(m[i], out);
      check_val({tag, "_m_times_inv"}, prod, ident());
      x = N'($urandom);
      check_val({tag, "_roundtrip"}, vmul(vmul(x, m), out), x);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    mat_t m, m2, out, expm;
    int   lat, busy_n, dones;
    logic sing;

    rst       = 1'b1;
    start     = 1'b0;
    matrix_in = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_singular", singular, 1'b0);
    check_val("rst_out", matrix_out, '0);
    // start together with rst must be ignored
    start     = 1'b1;
    matrix_in = ident();
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    check_val("rst_over_start", busy, 1'b0);

    // identity
    m = ident();
    run_one(m, 0, m, lat, busy_n, sing, out);
    verify("identity", m, lat, busy_n, sing, out);
    check_val("identity_out", out, ident());

    // upper bidiagonal -> upper-triangular all-ones
    m = '0;
    expm = '0;
    for (int i = 0; i < N; i++) begin
      m[i][i] = 1'b1;
      if (i < N - 1) m[i][i+1] = 1'b1;
      for (int j = i; j < N; j++) expm[i][j] = 1'b1;
    end
    run_one(m, 0, m, lat, busy_n, sing, out);
    verify("bidiag", m, lat, busy_n, sing, out);
    check_val("bidiag_out", out, expm);

    // start pulsed while busy is ignored
    m2 = ident();
    run_one(m, 4, m2, lat, busy_n, sing, out);
    verify("start_while_busy", m, lat, busy_n, sing, out);
    check_val("start_while_busy_out", out, expm);

    // identity with column 5 zeroed
    m2 = ident();
    m2[5][5] = 1'b0;
    run_one(m2, 0, m2, lat, busy_n, sing, out);
    verify("zero_col5", m2, lat, busy_n, sing, out);
    check_val("zero_col5_sing", sing, 1'b1);
    check_val("zero_col5_lat", lat, 12);

    // duplicate rows 3 and 7
    m2 = m;
    m2[7] = m2[3];
    run_one(m2, 0, m2, lat, busy_n, sing, out);
    verify("dup_rows", m2, lat, busy_n, sing, out);
    check_val("dup_rows_sing", sing, 1'b1);

    // anti-identity is its own inverse
    m = '0;
    for (int i = 0; i < N; i++) m[i][N-1-i] = 1'b1;
    run_one(m, 0, m, lat, busy_n, sing, out);
    verify("anti_ident", m, lat, busy_n, sing, out);
    check_val("anti_ident_out", out, m);

    // reset in the middle of an operation
    @(negedge clk);
    start     = 1'b1;
    matrix_in = expm;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_done", done, 1'b0);
    check_val("abort_singular", singular, 1'b0);
    check_val("abort_out", matrix_out, '0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check_val("abort_quiet", dones, 0);
    m = rand_invertible();
    run_one(m, 0, m, lat, busy_n, sing, out);
    verify("after_abort", m, lat, busy_n, sing, out);

    // randomized: invertible, fully random, and forced-duplicate matrices
    for (int t = 0; t < 500; t++) begin
      m = rand_invertible();
      run_one(m, 0, m, lat, busy_n, sing, out);
      verify("rand_inv", m, lat, busy_n, sing, out);
    end
    for (int t = 0; t < 120; t++) begin
      m = rand_mat();
      run_one(m, 0, m, lat, busy_n, sing, out);
      verify("rand_any", m, lat, busy_n, sing, out);
    end
    for (int t = 0; t < 40; t++) begin
      m = rand_invertible();
      m[$urandom_range(N - 1)] = m[$urandom_range(N - 1)] ^ m[$urandom_range(N - 1)];
      run_one(m, 0, m, lat, busy_n, sing, out);
      verify("rand_dep", m, lat, busy_n, sing, out);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
